// File: rtl/xcel_mem_responder.sv
// Single-outstanding val/rdy memory responder with fixed response latency.
// Optional out-of-range checking is enabled by defining XCEL_MEM_OOB_CHECK_EN.
module xcel_mem_responder #(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memreq_val_i,
  output logic        memreq_rdy_o,
  input  logic        memreq_type_i,
  input  logic [31:0] memreq_addr_i,
  input  logic [31:0] memreq_data_i,
  output logic        memresp_val_o,
  input  logic        memresp_rdy_i,
  output logic        memresp_type_o,
  output logic [31:0] memresp_data_o,
  output logic        memresp_err_o
);

  localparam int unsigned IDX_W    = $clog2(NUM_WORDS);
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CNT_LOAD = (LATENCY > 1) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_type_q, req_type_d;
  logic [IDX_W-1:0]    req_idx_q, req_idx_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic                req_oob_q, req_oob_d;
  logic                rdy_q, rdy_d;
  logic                val_q, val_d;
  logic                resp_type_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_err_q;

  logic [DATA_W-1:0]   mem_q [NUM_WORDS];

  logic                accept_c;
  logic                commit_c;
  logic                mem_we_c;
  logic [IDX_W-1:0]    req_idx_c;
  logic                req_oob_c;
  logic                cmt_type_c;
  logic [IDX_W-1:0]    cmt_idx_c;
  logic [DATA_W-1:0]   cmt_data_c;
  logic                cmt_oob_c;
  logic                unused_addr_c;

  assign req_idx_c     = memreq_addr_i[IDX_W+1:2];
  assign unused_addr_c = ^{memreq_addr_i[1:0], memreq_addr_i[31:IDX_W+2]};

`ifdef XCEL_MEM_OOB_CHECK_EN
  assign req_oob_c = |memreq_addr_i[31:IDX_W+2];
`else
  assign req_oob_c = 1'b0;
`endif

  assign accept_c = memreq_val_i & rdy_q & (state_q == S_IDLE);

  // With LATENCY=1 the access commits on the accept edge, straight from the inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      cmt_type_c = memreq_type_i;
      cmt_idx_c  = req_idx_c;
      cmt_data_c = memreq_data_i;
      cmt_oob_c  = req_oob_c;
    end else begin
      cmt_type_c = req_type_q;
      cmt_idx_c  = req_idx_q;
      cmt_data_c = req_data_q;
      cmt_oob_c  = req_oob_q;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_type_d = req_type_q;
    req_idx_d  = req_idx_q;
    req_data_d = req_data_q;
    req_oob_d  = req_oob_q;
    rdy_d      = 1'b0;
    val_d      = 1'b0;
    commit_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (accept_c) begin
          req_type_d = memreq_type_i;
          req_idx_d  = req_idx_c;
          req_data_d = memreq_data_i;
          req_oob_d  = req_oob_c;
          rdy_d      = 1'b0;
          if (LATENCY == 32'd1) begin
            state_d  = S_RESP;
            val_d    = 1'b1;
            commit_c = 1'b1;
          end else begin
            state_d  = S_WAIT;
            cnt_d    = CNT_W'(CNT_LOAD);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          val_d    = 1'b1;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        val_d = 1'b1;
        if (memresp_rdy_i) begin
          state_d = S_IDLE;
          val_d   = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_type_q  <= 1'b0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
      req_oob_q   <= 1'b0;
      rdy_q       <= 1'b0;
      val_q       <= 1'b0;
      resp_type_q <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_type_q <= req_type_d;
      req_idx_q  <= req_idx_d;
      req_data_q <= req_data_d;
      req_oob_q  <= req_oob_d;
      rdy_q      <= rdy_d;
      val_q      <= val_d;
      // Response registers only move on commit, so they hold while stalled.
      if (commit_c) begin
        resp_type_q <= cmt_type_c;
        resp_err_q  <= cmt_oob_c;
        resp_data_q <= (cmt_type_c || cmt_oob_c) ? '0 : mem_q[cmt_idx_c];
      end
    end
  end

  // Storage is intentionally not reset; reset only blocks an uncommitted write.
  assign mem_we_c = commit_c & cmt_type_c & ~cmt_oob_c & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      mem_q[cmt_idx_c] <= cmt_data_c;
    end
  end

  assign memreq_rdy_o   = rdy_q;
  assign memresp_val_o  = val_q;
  assign memresp_type_o = resp_type_q;
  assign memresp_data_o = resp_data_q;
`ifdef XCEL_MEM_OOB_CHECK_EN
  assign memresp_err_o  = resp_err_q;
`else
  assign memresp_err_o  = 1'b0;
`endif

endmodule
